// File: rtl/coffee_phase_timer.sv
// coffee_phase_timer
//   Times each brewing phase announced by the coffee-machine controller on TH_M and drives
//   the controller's T input. Each phase loads a prescaled down-counter; T flips to the
//   phase's expiry value when the count reaches zero.
//
// Parameters:
//   TICK_DIV     clock cycles per timer tick (>= 1)
//   CW           counter width
//   WORK_TICKS   WORKING length in ticks
//   COFFEE_TICKS POURINGCOFFEE length in ticks
//   MILK_TICKS   POURINGMILK length in ticks
//   DONE_TICKS   DONE hold length in ticks
//   WDOG_TICKS   stall limit in ticks (watchdog build only)
//
// Ports:
//   CLK   in   clock, rising edge
//   R     in   synchronous active-high reset
//   TH_M  in   3-bit controller status code
//   T     out  registered timer flag to the controller
//   REM   out  registered remaining ticks of the current phase
//   BUSY  out  high while REM != 0 in a timed phase
//   WDOG  out  sticky stall flag
//
// Build option: define COFFEE_TIMER_WDOG_EN to build the stall watchdog. Without it WDOG
// is tied to 0.

module coffee_phase_timer #(
    parameter int unsigned TICK_DIV     = 1,
    parameter int unsigned CW           = 8,
    parameter int unsigned WORK_TICKS   = 8,
    parameter int unsigned COFFEE_TICKS = 16,
    parameter int unsigned MILK_TICKS   = 8,
    parameter int unsigned DONE_TICKS   = 4,
    parameter int unsigned WDOG_TICKS   = 64
) (
    input  logic          CLK,
    input  logic          R,
    input  logic [2:0]    TH_M,
    output logic          T,
    output logic [CW-1:0] REM,
    output logic          BUSY,
    output logic          WDOG
);

    typedef enum logic [2:0] {
        StStandby    = 3'd0,
        StWorking    = 3'd1,
        StPourCoffee = 3'd2,
        StPourMilk   = 3'd3,
        StNeedMilk   = 3'd4,
        StDone       = 3'd5,
        StEnjoy      = 3'd6,
        StInvalid    = 3'd7
    } status_e;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam longint unsigned MaxDur = (64'd1 << CW) - 64'd1;

    // Elaboration-time parameter checks.
    if (TICK_DIV < 1) begin : g_bad_div
        $error("coffee_phase_timer: TICK_DIV must be at least 1");
    end
    if (longint'(WORK_TICKS) > MaxDur || longint'(COFFEE_TICKS) > MaxDur ||
        longint'(MILK_TICKS) > MaxDur || longint'(DONE_TICKS) > MaxDur) begin : g_bad_dur
        $error("coffee_phase_timer: phase duration does not fit in CW bits");
    end
    if (WDOG_TICKS < 1) begin : g_bad_wdog
        $error("coffee_phase_timer: WDOG_TICKS must be at least 1");
    end

    status_e       th_code;
    status_e       status_q, status_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          t_q, t_d;
    logic [CW-1:0] load_rem;
    logic          phase_start;
    logic          pre_wrap;
    logic          tick;
    logic          is_high;
    logic          is_done;

    assign th_code     = status_e'(TH_M);
    assign phase_start = (th_code != status_q);
    assign pre_wrap    = (pre_q == PW'(TICK_DIV - 1));
    assign tick        = pre_wrap && !phase_start;
    assign is_high     = (status_q == StWorking) || (status_q == StPourCoffee) ||
                         (status_q == StPourMilk);
    assign is_done     = (status_q == StDone);

    // Duration loaded for the incoming code; untimed codes load 0.
    always_comb begin
        load_rem = '0;
        case (th_code)
            StWorking:    load_rem = CW'(WORK_TICKS);
            StPourCoffee: load_rem = CW'(COFFEE_TICKS);
            StPourMilk:   load_rem = CW'(MILK_TICKS);
            StDone:       load_rem = CW'(DONE_TICKS);
            default:      load_rem = '0;
        endcase
    end

    always_comb begin
        status_d = status_q;
        pre_d    = pre_q;
        rem_d    = rem_q;
        t_d      = t_q;
        if (phase_start) begin
            // A reload always beats a coincident tick or expiry.
            status_d = th_code;
            pre_d    = '0;
            rem_d    = load_rem;
            t_d      = (th_code == StDone);
        end else begin
            pre_d = pre_wrap ? '0 : pre_q + 1'b1;
            if (tick && (rem_q != '0)) begin
                rem_d = rem_q - 1'b1;
                if (rem_q == CW'(1)) begin
                    t_d = is_high && !is_done;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            status_q <= StStandby;
            pre_q    <= '0;
            rem_q    <= '0;
            t_q      <= 1'b0;
        end else begin
            status_q <= status_d;
            pre_q    <= pre_d;
            rem_q    <= rem_d;
            t_q      <= t_d;
        end
    end

    assign T    = t_q;
    assign REM  = rem_q;
    assign BUSY = (rem_q != '0) && (is_high || is_done);

`ifdef COFFEE_TIMER_WDOG_EN
    localparam int unsigned SW = $clog2(WDOG_TICKS + 1);

    logic [SW-1:0] stall_q, stall_d;
    logic          wdog_q, wdog_d;

    // Counts ticks spent parked in an expired expire-high phase; saturates at the limit.
    always_comb begin
        stall_d = stall_q;
        wdog_d  = wdog_q;
        if (phase_start) begin
            stall_d = '0;
        end else if (tick && is_high && t_q && (stall_q != SW'(WDOG_TICKS))) begin
            stall_d = stall_q + 1'b1;
            if (stall_q == SW'(WDOG_TICKS - 1)) begin
                wdog_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            stall_q <= '0;
            wdog_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            wdog_q  <= wdog_d;
        end
    end

    assign WDOG = wdog_q;
`else
    assign WDOG = 1'b0;
`endif

endmodule

// File: tb/tb_coffee_phase_timer.sv
// Directed bench for coffee_phase_timer. u_dut1 runs with TICK_DIV=1, u_dut2 with
// TICK_DIV=2; both share the clock. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point.

module tb_coffee_phase_timer;

`ifdef COFFEE_TIMER_WDOG_EN
    localparam bit WdogOn = 1'b1;
`else
    localparam bit WdogOn = 1'b0;
`endif

    logic       clk;
    logic       r1, r2;
    logic [2:0] th1, th2;
    logic       t1, t2, busy1, busy2, wdog1, wdog2;
    logic [7:0] rem1, rem2;

    int checks   = 0;
    int failures = 0;

    coffee_phase_timer u_dut1 (
        .CLK  (clk),
        .R    (r1),
        .TH_M (th1),
        .T    (t1),
        .REM  (rem1),
        .BUSY (busy1),
        .WDOG (wdog1)
    );

    coffee_phase_timer #(
        .TICK_DIV (2)
    ) u_dut2 (
        .CLK  (clk),
        .R    (r2),
        .TH_M (th2),
        .T    (t2),
        .REM  (rem2),
        .BUSY (busy2),
        .WDOG (wdog2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {T, REM, BUSY, WDOG} compared as one vector per cycle.
    task automatic test_reset();
        logic [10:0] exp_v;
        r1 = 1'b1; r2 = 1'b1; th1 = 3'd0; th2 = 3'd0;
        exp_v = {1'b0, 8'd0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                r1 = 1'b0; r2 = 1'b0;
            end
            step();
            checks++;
            if ({t1, rem1, busy1, wdog1} !== exp_v) begin
                failures++;
                $display("FAIL reset_dut1 cyc=%0d got=%h want=%h", i, {t1, rem1, busy1, wdog1},
                         exp_v);
            end
            checks++;
            if ({t2, rem2, busy2, wdog2} !== exp_v) begin
                failures++;
                $display("FAIL reset_dut2 cyc=%0d got=%h want=%h", i, {t2, rem2, busy2, wdog2},
                         exp_v);
            end
        end
    endtask

    task automatic test_working();
        logic [9:0] exp_v;
        th1 = 3'd1;
        step();
        for (int i = 0; i <= 10; i++) begin
            // i = ticks since load; REM saturates at 0 and T rises at the 8th tick.
            exp_v = {(i >= 8), (i >= 8) ? 8'd0 : 8'(8 - i), (i < 8)};
            checks++;
            if ({t1, rem1, busy1} !== exp_v) begin
                failures++;
                $display("FAIL working i=%0d got T=%b REM=%0d BUSY=%b want %h", i, t1, rem1,
                         busy1, exp_v);
            end
            step();
        end
        th1 = 3'd0;
        step();
        checks++;
        if ({t1, rem1, busy1} !== 10'd0) begin
            failures++;
            $display("FAIL working_to_standby got T=%b REM=%0d BUSY=%b want 0", t1, rem1, busy1);
        end
    endtask

    task automatic test_reload_wins();
        th1 = 3'd1;
        step();
        for (int i = 0; i < 7; i++) step();
        checks++;
        if ({t1, rem1} !== {1'b0, 8'd1}) begin
            failures++;
            $display("FAIL reload_pre got T=%b REM=%0d want T=0 REM=1", t1, rem1);
        end
        th1 = 3'd2;
        step();
        checks++;
        if ({t1, rem1} !== {1'b0, 8'd16}) begin
            failures++;
            $display("FAIL reload_wins got T=%b REM=%0d want T=0 REM=16", t1, rem1);
        end
        step();
        checks++;
        if ({t1, rem1} !== {1'b0, 8'd15}) begin
            failures++;
            $display("FAIL reload_next got T=%b REM=%0d want T=0 REM=15", t1, rem1);
        end
        th1 = 3'd0;
        step();
    endtask

    task automatic test_mid_reset();
        th1 = 3'd3;
        step();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (rem1 !== 8'd5) begin
            failures++;
            $display("FAIL midreset_pre got REM=%0d want 5", rem1);
        end
        r1 = 1'b1;
        step();
        checks++;
        if ({t1, rem1, busy1} !== 10'd0) begin
            failures++;
            $display("FAIL midreset_abort got T=%b REM=%0d BUSY=%b want 0", t1, rem1, busy1);
        end
        r1 = 1'b0;
        step();
        checks++;
        if ({t1, rem1, busy1} !== {1'b0, 8'd8, 1'b1}) begin
            failures++;
            $display("FAIL midreset_reload got T=%b REM=%0d BUSY=%b want T=0 REM=8 BUSY=1", t1,
                     rem1, busy1);
        end
        step();
        checks++;
        if (rem1 !== 8'd7) begin
            failures++;
            $display("FAIL midreset_count got REM=%0d want 7", rem1);
        end
        th1 = 3'd0;
        step();
    endtask

    task automatic test_done_hold();
        th2 = 3'd2;
        step();
        for (int i = 0; i < 32; i++) step();
        checks++;
        if ({t2, rem2} !== {1'b1, 8'd0}) begin
            failures++;
            $display("FAIL coffee_expire got T=%b REM=%0d want T=1 REM=0", t2, rem2);
        end
        th2 = 3'd5;
        step();
        for (int i = 0; i <= 8; i++) begin
            // TICK_DIV=2: REM drops every second edge, T falls at E0+8.
            checks++;
            if ({t2, rem2} !== {(i < 8), 8'(4 - i / 2)}) begin
                failures++;
                $display("FAIL done_hold i=%0d got T=%b REM=%0d want T=%b REM=%0d", i, t2, rem2,
                         (i < 8), 4 - i / 2);
            end
            if (i < 8) step();
        end
        th2 = 3'd6;
        step();
        checks++;
        if ({t2, rem2, busy2} !== 10'd0) begin
            failures++;
            $display("FAIL enjoy got T=%b REM=%0d BUSY=%b want 0", t2, rem2, busy2);
        end
    endtask

    task automatic test_watchdog();
        r1 = 1'b1;
        step();
        r1 = 1'b0;
        th1 = 3'd1;
        step();
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (t1 !== 1'b1) begin
            failures++;
            $display("FAIL wdog_setup got T=%b want 1", t1);
        end
        for (int i = 0; i < 63; i++) step();
        checks++;
        if (wdog1 !== 1'b0) begin
            failures++;
            $display("FAIL wdog_early got WDOG=%b want 0", wdog1);
        end
        step();
        checks++;
        if (wdog1 !== WdogOn) begin
            failures++;
            $display("FAIL wdog_fire got WDOG=%b want %b", wdog1, WdogOn);
        end
        th1 = 3'd2;
        step();
        step();
        checks++;
        if (wdog1 !== WdogOn) begin
            failures++;
            $display("FAIL wdog_sticky got WDOG=%b want %b", wdog1, WdogOn);
        end
        r1 = 1'b1;
        step();
        checks++;
        if (wdog1 !== 1'b0) begin
            failures++;
            $display("FAIL wdog_clear got WDOG=%b want 0", wdog1);
        end
        r1 = 1'b0;
        th1 = 3'd0;
        step();
    endtask

    initial begin
        test_reset();
        test_working();
        test_reload_wins();
        test_mid_reset();
        test_done_hold();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
